// File: rtl/pc_gen_if.sv
// Fetch-side bundle of the PC generator: control/redirect inputs and the
// registered fetch request it drives toward instruction memory.
interface pc_gen_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int COUNT_WIDTH = 32
);
    // Handshake: a fetch is accepted on a rising edge where pc_valid & if_ready
    // & ~stall; while pc_valid & ~(if_ready & ~stall) pc stays put unless a
    // trap/branch redirect replaces it.
    logic                   stall;
    logic                   if_ready;
    logic                   br_taken;
    logic [ADDR_WIDTH-1:0]  br_target;
    logic                   trap_req;
    logic [ADDR_WIDTH-1:0]  trap_vec;
    logic                   halt;
    logic                   resume;
    logic [ADDR_WIDTH-1:0]  pc;
    logic                   pc_valid;
    logic                   misalign;
    logic [COUNT_WIDTH-1:0] fetch_count;

    modport master (
        input  stall, if_ready, br_taken, br_target, trap_req, trap_vec, halt, resume,
        output pc, pc_valid, misalign, fetch_count
    );

    modport slave (
        output stall, if_ready, br_taken, br_target, trap_req, trap_vec, halt, resume,
        input  pc, pc_valid, misalign, fetch_count
    );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator: boot delay, RUN/HALT control, prioritised
// trap/branch redirects with alignment forcing, and an accepted-fetch counter.
module pc_gen #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    STEP         = 4,
    parameter int                    ALIGN_BITS   = 2,
    parameter int                    BOOT_CYCLES  = 4,
    parameter int                    COUNT_WIDTH  = 32
) (
    input  logic          clk,
    input  logic          rst,
    pc_gen_if.master      bus,
    output logic [1:0]    dbg_state
);
    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;
    localparam logic [1:0] ST_INIT = (BOOT_CYCLES == 0) ? ST_RUN : ST_BOOT;

    localparam int BW = (BOOT_CYCLES > 0) ? $clog2(BOOT_CYCLES + 1) : 1;
    localparam logic [BW-1:0]         BOOT_LAST = BW'(BOOT_CYCLES);
    localparam logic [ADDR_WIDTH-1:0] STEP_V    = ADDR_WIDTH'(STEP);
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK  = ADDR_WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

    logic [1:0]             state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic                   pc_valid_q, pc_valid_d;
    logic                   misalign_q, misalign_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [BW-1:0]          boot_q, boot_d;
    logic                   fire;

    assign fire = pc_valid_q & bus.if_ready & ~bus.stall;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        count_d    = count_q;
        boot_d     = boot_q;
        misalign_d = 1'b0;
        case (state_q)
            ST_BOOT: begin
                if (boot_q == BOOT_LAST) state_d = ST_RUN;
                else                     boot_d  = boot_q + 1'b1;
            end
            ST_RUN: begin
                // Trap outranks branch, so a losing br_target is never alignment-checked.
                if (bus.trap_req) begin
                    pc_d       = bus.trap_vec & ~LOW_MASK;
                    misalign_d = |(bus.trap_vec & LOW_MASK);
                end else if (bus.br_taken) begin
                    pc_d       = bus.br_target & ~LOW_MASK;
                    misalign_d = |(bus.br_target & LOW_MASK);
                end else if (bus.halt) begin
                    state_d = ST_HALT;
                end else if (fire) begin
                    pc_d    = pc_q + STEP_V;
                    count_d = count_q + 1'b1;
                end
            end
            ST_HALT: begin
                if (bus.trap_req) begin
                    pc_d       = bus.trap_vec & ~LOW_MASK;
                    misalign_d = |(bus.trap_vec & LOW_MASK);
                    state_d    = ST_RUN;
                end else begin
                    if (bus.br_taken) begin
                        pc_d       = bus.br_target & ~LOW_MASK;
                        misalign_d = |(bus.br_target & LOW_MASK);
                    end
                    if (bus.resume) state_d = ST_RUN;
                end
            end
            default: state_d = ST_INIT;
        endcase
        // Registered valid tracks the state being entered, so it moves on the same edge.
        pc_valid_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_INIT;
            pc_q       <= RESET_VECTOR;
            pc_valid_q <= 1'b0;
            misalign_q <= 1'b0;
            count_q    <= '0;
            boot_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            misalign_q <= misalign_d;
            count_q    <= count_d;
            boot_q     <= boot_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_valid    = pc_valid_q;
    assign bus.misalign    = misalign_q;
    assign bus.fetch_count = count_q;
    assign dbg_state       = state_q;
endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator: the next-generation replacement for the single-register PC. It drives fetch addresses through a valid/ready handshake, with stall and halt, prioritised trap/branch redirect, alignment checking, a post-reset boot delay and a fetch counter. It sits at the head of the fetch stage, between control/hazard logic and the instruction memory port.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of PC and redirect targets
- RESET_VECTOR, 0, PC value loaded at reset
- STEP, 4, sequential increment in bytes
- ALIGN_BITS, 2, number of low PC bits that must be zero
- BOOT_CYCLES, 4, cycles after reset release before the first valid PC; 0 allowed
- COUNT_WIDTH, 32, width of the fetch counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- stall  in  1  hold the PC; no advance
- if_ready  in  1  fetch accepts the current PC
- br_taken  in  1  branch/jump redirect request
- br_target  in  ADDR_WIDTH  branch target
- trap_req  in  1  trap redirect request; beats br_taken
- trap_vec  in  ADDR_WIDTH  trap target
- halt  in  1  request halt
- resume  in  1  leave HALT
- pc  out  ADDR_WIDTH  current fetch address, registered
- pc_valid  out  1  pc is a valid fetch request
- misalign  out  1  one-cycle pulse when an accepted redirect target was misaligned
- fetch_count  out  COUNT_WIDTH  number of accepted fetches

## Operation
- Reset (rst=0): pc=RESET_VECTOR, pc_valid=0, misalign=0, fetch_count=0, boot counter=0. State is BOOT, or RUN if BOOT_CYCLES=0.
- States: BOOT, RUN, HALT.
- BOOT:
  - Count cycles after reset release. After BOOT_CYCLES cycles, move to RUN.
  - All redirect, halt and resume inputs are ignored. pc_valid=0.
- RUN: pc_valid=1. Per-cycle priority, highest first:
  - trap_req: pc <= trap_vec.
  - br_taken: pc <= br_target.
  - halt: go to HALT, pc held.
  - fire (if_ready & ~stall): pc <= pc + STEP, wrapping mod 2^ADDR_WIDTH.
  - Otherwise pc is held.
- Redirects:
  - Override stall and if_ready. The current PC is discarded and not counted.
- Halt:
  - When halt coincides with a redirect, the redirect is taken and halt is re-sampled next cycle.
- fetch_count increments only on fire with no redirect. It wraps to 0 past all-ones.
- Alignment:
  - Any loaded redirect target has its low ALIGN_BITS forced to 0.
  - If those bits were nonzero, misalign=1 on the cycle after the load.
- HALT: pc_valid=0, pc held.
  - trap_req: load trap_vec and go to RUN.
  - br_taken: load br_target and stay in HALT.
  - resume (with no trap): go to RUN.
- Reset mid-operation: asynchronously returns every output to its reset value, regardless of state.

## Timing
- Every output is registered. Redirect-to-pc latency is 1 cycle, the same as sequential advance.
- pc_valid first rises on the (BOOT_CYCLES+1)th rising edge after rst goes high. With BOOT_CYCLES=0 it rises on the 1st edge.
- HALT entry: pc_valid falls on the edge that samples halt.
- HALT exit: pc_valid rises on the edge that samples resume or trap_req.
- Handshake: pc holds stable while pc_valid & ~if_ready, unless a redirect arrives.
- misalign is high for exactly 1 cycle per misaligned redirect. Back-to-back misaligned redirects keep it high.
- Simultaneous trap_req and br_taken: trap_vec wins, and br_target's alignment is not checked.

## Test plan
- Reset, BOOT_CYCLES=4, if_ready=1 -> pc=0, pc_valid=0 for 4 edges. Then pc=0 valid, followed by 4, 8, 12; fetch_count=3 when pc=12.
- RUN at pc=0x100, stall=1 for 3 cycles, br_taken=1 with br_target=0x200 in the 2nd stall cycle -> pc=0x200 next edge; fetch_count unchanged.
- trap_req=1 with trap_vec=0x80, br_taken=1 with br_target=0x400, same cycle -> pc=0x80, misalign=0.
- br_target=0x203 -> pc=0x200, misalign pulses for 1 cycle.
- ADDR_WIDTH=8, pc=0xFC, fire -> pc=0x00. fetch_count wraps from all-ones to 0.
- Halt at pc=0x40 -> pc_valid=0 and pc=0x40 held 5 cycles. Then br_target=0x60 -> pc=0x60, still halted. Then resume -> pc_valid=1. Finally assert rst=0 mid-run -> pc=RESET_VECTOR, pc_valid=0 immediately.
